// File: rtl/float_to_double_pkg.sv
// Shared constants, field layouts and helpers for the binary32 -> binary64 converter.
package float_to_double_pkg;

   // Field widths of both formats
   localparam int FLT_SIGN_W = 1;
   localparam int FLT_EXP_W  = 8;
   localparam int FLT_FRAC_W = 23;
   localparam int DBL_SIGN_W = 1;
   localparam int DBL_EXP_W  = 11;
   localparam int DBL_FRAC_W = 52;

   // Exponent biases and the derived re-bias amounts
   localparam int FLT_BIAS       = 127;
   localparam int DBL_BIAS       = 1023;
   localparam int BIAS_DELTA     = DBL_BIAS - FLT_BIAS;                  // 896
   localparam int SUBNORM_OFFSET = DBL_BIAS - FLT_BIAS - (FLT_FRAC_W - 1); // 874

   // Zero padding that left-aligns a binary32 fraction in a binary64 fraction
   localparam int FRAC_PAD = DBL_FRAC_W - FLT_FRAC_W;                    // 29

   // All-ones exponents mark infinity / NaN
   localparam logic [FLT_EXP_W-1:0] FLT_EXP_ONES = '1;
   localparam logic [DBL_EXP_W-1:0] DBL_EXP_ONES = '1;

   typedef struct packed {
      logic [FLT_SIGN_W-1:0] sign;
      logic [FLT_EXP_W-1:0]  exp;
      logic [FLT_FRAC_W-1:0] frac;
   } float_t;

   typedef struct packed {
      logic [DBL_SIGN_W-1:0] sign;
      logic [DBL_EXP_W-1:0]  exp;
      logic [DBL_FRAC_W-1:0] frac;
   } double_t;

   // A signaling NaN has an all-ones exponent, a clear quiet bit and a non-zero payload
   function automatic logic is_snan(input float_t f);
      return (f.exp == FLT_EXP_ONES) && !f.frac[FLT_FRAC_W-1] && (f.frac != '0);
   endfunction

endpackage

// File: rtl/ftd_lzc23.sv
// Combinational 23-bit leading-zero counter; an all-zero input yields 23.
module ftd_lzc23 (
   input  logic [22:0] value,
   output logic [4:0]  count
);

   // zero_above[i] is set when bit i and every bit above it are zero
   logic [22:0] zero_above;

   genvar gi;
   generate
      for (gi = 0; gi < 23; gi++) begin : g_prefix
         assign zero_above[gi] = ~|value[22:gi];
      end
   endgenerate

   // The leading-zero count is the number of positions with nothing set at or above them
   always_comb begin
      count = 5'd0;
      for (int i = 0; i < 23; i++) begin
         count = count + {4'd0, zero_above[i]};
      end
   end

endmodule

// File: rtl/float_to_double.sv
// IEEE 754 binary32 -> binary64 converter with a single output register stage.
// Build option: define FTD_SUBNORMAL_EN to normalize subnormal inputs;
// without it subnormals flush to signed zero and no leading-zero counter is built.
module float_to_double
   import float_to_double_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] float,
   output logic [63:0] double,
   output logic        nan_exception
);

   float_t  flt;
   double_t double_next;
   logic    nan_next;
   logic [63:0] double_reg;
   logic        nan_reg;

   assign flt = float;

`ifdef FTD_SUBNORMAL_EN
   logic [4:0]            lzc_count;
   logic [4:0]            msb_pos;
   logic [DBL_EXP_W-1:0]  sub_exp;
   logic [FLT_FRAC_W-1:0] sub_frac;

   ftd_lzc23 u_lzc (
      .value (flt.frac),
      .count (lzc_count)
   );

   // Leading one sits at bit 22-lzc; shifting past it drops the implicit bit
   assign msb_pos  = 5'd22 - lzc_count;
   assign sub_exp  = DBL_EXP_W'(SUBNORM_OFFSET) + {6'd0, msb_pos};
   assign sub_frac = flt.frac << (lzc_count + 5'd1);
`endif

   // Classify the operand and build the widened result
   always_comb begin
      double_next      = '0;
      double_next.sign = flt.sign;
      nan_next         = 1'b0;
      if (flt.exp == FLT_EXP_ONES) begin
         double_next.exp = DBL_EXP_ONES;
         if (flt.frac != '0) begin
            // Force the quiet bit, keep the remaining payload
            double_next.frac = {1'b1, flt.frac[FLT_FRAC_W-2:0], {FRAC_PAD{1'b0}}};
            nan_next         = is_snan(flt);
         end
      end else if (flt.exp == '0) begin
`ifdef FTD_SUBNORMAL_EN
         if (flt.frac != '0) begin
            double_next.exp  = sub_exp;
            double_next.frac = {sub_frac, {FRAC_PAD{1'b0}}};
         end
`endif
      end else begin
         double_next.exp  = {3'd0, flt.exp} + DBL_EXP_W'(BIAS_DELTA);
         double_next.frac = {flt.frac, {FRAC_PAD{1'b0}}};
      end
   end

   // Output register; reset clears the result immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         double_reg <= 64'h0;
         nan_reg    <= 1'b0;
      end else begin
         double_reg <= double_next;
         nan_reg    <= nan_next;
      end
   end

   assign double        = double_reg;
   assign nan_exception = nan_reg;

endmodule

// File: tb/tb_float_to_double.sv
// Self-checking bench for float_to_double: directed vectors plus random operands
// compared against an arithmetic reference model.
module tb_float_to_double;

   logic        clk;
   logic        reset;
   logic [31:0] float;
   logic [63:0] double;
   logic        nan_exception;

   int checks = 0;
   int passed = 0;

   float_to_double dut (
      .clk           (clk),
      .reset         (reset),
      .float         (float),
      .double        (double),
      .nan_exception (nan_exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value-level conversion following the format definitions
   function automatic logic [64:0] ref_conv(input logic [31:0] f);
      logic        s;
      int          e;
      longint      m;
      int          sh;
      logic [10:0] e64;
      logic [51:0] f64;
      logic        snan;
      s    = f[31];
      e    = int'(f[30:23]);
      m    = longint'(f[22:0]);
      e64  = 11'd0;
      f64  = 52'd0;
      snan = 1'b0;
      if (e == 255) begin
         e64 = 11'h7FF;
         if (m != 0) begin
            f64  = {1'b1, f[21:0], 29'd0};
            snan = (f[22] == 1'b0);
         end
      end else if (e == 0) begin
`ifdef FTD_SUBNORMAL_EN
         if (m != 0) begin
            // value = m * 2^-149; scale m until it has a leading bit at 2^23
            sh = 0;
            while (m < (64'sd1 <<< 23)) begin
               m  = m <<< 1;
               sh = sh + 1;
            end
            // value = 1.frac * 2^(-126-sh)
            e64 = 11'(1023 - 126 - sh);
            f64 = 52'((m & 64'sh7FFFFF) <<< 29);
         end
`endif
      end else begin
         e64 = 11'(e - 127 + 1023);
         f64 = 52'(m <<< 29);
      end
      return {snan, s, e64, f64};
   endfunction

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Drive one operand, let one edge capture it, compare to model and optional literal
   task automatic step(input string tag, input logic [31:0] f,
                       input logic use_lit, input logic [63:0] lit_d, input logic lit_n);
      logic [64:0] r;
      @(negedge clk);
      float = f;
      r = ref_conv(f);
      @(posedge clk);
      #1;
      check64({tag, "_dbl"}, double, r[63:0]);
      check1({tag, "_nan"}, nan_exception, r[64]);
      if (use_lit) begin
         check64({tag, "_lit"}, double, lit_d);
         check1({tag, "_litnan"}, nan_exception, lit_n);
      end
      $display("step %-10s float=%h double=%h nan=%b", tag, f, double, nan_exception);
   endtask

   initial begin
      logic [31:0] rf;
      int          cls;
      reset = 1'b0;
      float = 32'h3F800000;

      // Held in reset while clocking: outputs stay cleared
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check64("rst_dbl", double, 64'h0);
         check1("rst_nan", nan_exception, 1'b0);
      end

      // Release between edges: nothing changes until the next rising edge
      @(negedge clk);
      reset = 1'b1;
      #1;
      check64("rel_hold", double, 64'h0);

      step("one",    32'h3F800000, 1'b1, 64'h3FF0000000000000, 1'b0);
      step("mtwo",   32'hC0000000, 1'b1, 64'hC000000000000000, 1'b0);
      step("maxn",   32'h7F7FFFFF, 1'b1, 64'h47EFFFFFE0000000, 1'b0);
      step("nzero",  32'h80000000, 1'b1, 64'h8000000000000000, 1'b0);
      step("pinf",   32'h7F800000, 1'b1, 64'h7FF0000000000000, 1'b0);
      step("ninf",   32'hFF800000, 1'b1, 64'hFFF0000000000000, 1'b0);
`ifdef FTD_SUBNORMAL_EN
      step("submin", 32'h00000001, 1'b1, 64'h36A0000000000000, 1'b0);
      step("subhi",  32'h00400000, 1'b1, 64'h3800000000000000, 1'b0);
      step("submax", 32'h007FFFFF, 1'b1, 64'h380FFFFFC0000000, 1'b0);
`else
      step("subflsh", 32'h80000001, 1'b1, 64'h8000000000000000, 1'b0);
      step("subfl2",  32'h007FFFFF, 1'b1, 64'h0000000000000000, 1'b0);
`endif
      step("minnorm", 32'h00800000, 1'b1, 64'h3810000000000000, 1'b0);
      step("qnan",   32'h7FC00000, 1'b1, 64'h7FF8000000000000, 1'b0);
      step("snan",   32'h7F800001, 1'b1, 64'h7FF8000020000000, 1'b1);

      // Asynchronous reset mid-cycle clears both outputs without a clock edge
      #2;
      reset = 1'b0;
      #1;
      check64("async_dbl", double, 64'h0);
      check1("async_nan", nan_exception, 1'b0);
      @(posedge clk);
      #1;
      check64("async_hold", double, 64'h0);
      @(negedge clk);
      reset = 1'b1;

      // Randomized operands, biased toward each operand class
      for (int n = 0; n < 300; n++) begin
         rf  = $urandom;
         cls = int'($urandom_range(0, 4));
         case (cls)
            1: rf[30:23] = 8'h00;
            2: rf[30:23] = 8'hFF;
            3: rf[30:0]  = 31'd0;
            default: ;
         endcase
         step("rand", rf, 1'b0, 64'h0, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
